// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem read port plus decode-side valid/ready, redirect and halt signals
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [DATA_W-1:0] imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;
    modport master (
        output imem_addr, imem_rd, if_valid, if_instr, if_pc,
        input  imem_data, redirect, redirect_pc, halt, if_ready
    );
    modport slave (
        input  imem_addr, imem_rd, if_valid, if_instr, if_pc,
        output imem_data, redirect, redirect_pc, halt, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues imem reads and buffers tagged words in a 2-entry queue.
// Define FETCH_PERF_EN to add saturating fetch/flush performance counters.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] pc, tag;
    logic inflight, issue, pop, push, room;
    logic [1:0] count, fill;
    logic [ADDR_W-1:0] q_pc [2];
    logic [DATA_W-1:0] q_instr [2];
    assign pop = bus.if_valid & bus.if_ready;
    assign push = inflight & ~bus.redirect;
    // Room counts the in-flight word, so the queue can never overflow.
    assign room = (3'(count) + 3'(inflight)) < (3'd2 + 3'(pop));
    assign fill = count - 2'(pop);
    assign bus.imem_addr = pc;
    assign bus.imem_rd = issue;
    assign bus.if_valid = count != 2'd0;
    assign bus.if_instr = q_instr[0];
    assign bus.if_pc = q_pc[0];
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else state <= state_next;
    end
    always_comb begin
        state_next = bus.halt ? HALT : RUN;
    end
    always_comb begin
        issue = (state == RUN) & ~bus.halt & ~bus.redirect & ~rst & room;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            tag <= '0;
            inflight <= 1'b0;
            count <= 2'd0;
            q_pc[0] <= '0;
            q_pc[1] <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= pc;
                pc <= pc + ADDR_W'(1);
            end
            if (bus.redirect) begin
                pc <= bus.redirect_pc;
                count <= 2'd0;
            end else begin
                if (pop) begin
                    q_pc[0] <= q_pc[1];
                    q_instr[0] <= q_instr[1];
                end
                // Written after the shift so a simultaneous push into slot 0 wins.
                if (push) begin
                    q_pc[fill[0]] <= tag;
                    q_instr[fill[0]] <= bus.imem_data;
                end
                count <= count - 2'(pop) + 2'(push);
            end
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.redirect && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif
endmodule
